// File: rtl/imem_loader_if.sv
// Host-side load bus and IMEM write port bundle for imem_loader.
// The checksum signal exists only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              write_to_imem;
  logic [ADDR_W-1:0] addr_imem_host;
  logic [DATA_W-1:0] imem_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport slave (
    input  start, base_addr, word_count, abort, host_valid, host_data,
    output host_ready, write_to_imem, addr_imem_host, imem_data,
           cpu_hold, busy, done, error, checksum
  );
  modport master (
    output start, base_addr, word_count, abort, host_valid, host_data,
    input  host_ready, write_to_imem, addr_imem_host, imem_data,
           cpu_hold, busy, done, error, checksum
  );
`else
  modport slave (
    input  start, base_addr, word_count, abort, host_valid, host_data,
    output host_ready, write_to_imem, addr_imem_host, imem_data,
           cpu_hold, busy, done, error
  );
  modport master (
    output start, base_addr, word_count, abort, host_valid, host_data,
    input  host_ready, write_to_imem, addr_imem_host, imem_data,
           cpu_hold, busy, done, error
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// Burst loader that streams host words into instruction memory while holding the CPU.
// Optional running checksum of accepted words is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
  logic [CNT_W-1:0]  remaining, remaining_nx;
  logic              wr_q, wr_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              err_q, err_nx;
  logic              ready_q, busy_q, done_q, hold_q;
  logic              accept_c;
  logic              count_ok_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_nx;
`endif

  // host_ready is a pure function of state, so accept never loops back through it
  assign accept_c   = (state == ST_LOAD) && bus.host_valid;
  assign count_ok_c = (bus.word_count != '0) && (bus.word_count <= MAX_WORDS);

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    cur_addr_nx  = cur_addr;
    remaining_nx = remaining;
    wr_nx        = 1'b0;
    addr_nx      = addr_q;
    data_nx      = data_q;
    err_nx       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_nx       = sum_q;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (count_ok_c) begin
            state_nx     = ST_LOAD;
            cur_addr_nx  = bus.base_addr;
            remaining_nx = bus.word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_nx       = '0;
`endif
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          wr_nx        = 1'b1;
          addr_nx      = cur_addr;
          data_nx      = bus.host_data;
          cur_addr_nx  = cur_addr + ADDR_W'(1);
          remaining_nx = remaining - CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_nx       = sum_q + bus.host_data;
`endif
        end
        // abort wins over completion: the last word is still written but done stays low
        if (bus.abort) begin
          state_nx = ST_IDLE;
        end else if (accept_c && (remaining == CNT_W'(1))) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state     <= state_nx;
      cur_addr  <= cur_addr_nx;
      remaining <= remaining_nx;
      wr_q      <= wr_nx;
      addr_q    <= addr_nx;
      data_q    <= data_nx;
      err_q     <= err_nx;
      ready_q   <= (state_nx == ST_LOAD);
      busy_q    <= (state_nx != ST_IDLE);
      done_q    <= (state_nx == ST_DONE);
      hold_q    <= (state_nx != ST_IDLE) || wr_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_nx;
`endif
    end
  end

  assign bus.host_ready     = ready_q;
  assign bus.write_to_imem  = wr_q;
  assign bus.addr_imem_host = addr_q;
  assign bus.imem_data      = data_q;
  assign bus.cpu_hold       = hold_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.checksum       = sum_q;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the IMEM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the IMEM word width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a load burst.
REQ-006 SHALL have port base_addr  input  ADDR_W  meaning the first IMEM address of the burst, sampled on accepted start.
REQ-007 SHALL have port word_count  input  ADDR_W+1  meaning the number of words in the burst (legal range 1..512), sampled on accepted start.
REQ-008 SHALL have port abort  input  1  meaning a request to end the burst early.
REQ-009 SHALL have port host_valid  input  1  meaning host_data holds a word.
REQ-010 SHALL have port host_data  input  DATA_W  meaning the instruction word from the host.
REQ-011 SHALL have port host_ready  output  1  meaning the loader accepts a word this cycle.
REQ-012 SHALL have port write_to_imem  output  1  meaning the IMEM write strobe, which also steers the IMEM address mux and freezes the PC.
REQ-013 SHALL have port addr_imem_host  output  ADDR_W  meaning the IMEM write address.
REQ-014 SHALL have port imem_data  output  DATA_W  meaning the IMEM write data.
REQ-015 SHALL have port cpu_hold  output  1  meaning the pipeline must be kept in reset or stalled.
REQ-016 SHALL have port busy  output  1  meaning a burst is in progress.
REQ-017 SHALL have port done  output  1  meaning a one-cycle pulse on burst completion.
REQ-018 SHALL have port error  output  1  meaning a one-cycle pulse when a start is rejected.

Function
REQ-019 SHALL implement the states IDLE, LOAD and DONE.
REQ-020 In IDLE, start with word_count in 1..512 SHALL move the FSM to LOAD, latch cur_addr=base_addr and remaining=word_count, and set busy=1 on the next cycle.
REQ-021 In IDLE, start with word_count=0 or word_count>512 SHALL pulse error for 1 cycle and leave the FSM in IDLE.
REQ-022 host_ready SHALL be 1 exactly when the state is LOAD, with no combinational path from host_valid.
REQ-023 A word SHALL be accepted in a cycle where host_valid and host_ready are both 1.
REQ-024 On the cycle after an accept, write_to_imem SHALL be 1 for exactly 1 cycle, with addr_imem_host=cur_addr and imem_data=host_data as registered at the accept.
REQ-025 Each accept SHALL increment cur_addr modulo 2^ADDR_W (511 wraps to 0) and decrement remaining.
REQ-026 An accept with remaining==1 SHALL move the FSM to DONE; the final write strobe therefore occurs during DONE.
REQ-027 DONE SHALL last exactly 1 cycle, with done=1 in that cycle, and SHALL then return to IDLE.
REQ-028 host_valid=0 in LOAD SHALL produce no write and leave cur_addr and remaining unchanged, with no timeout.
REQ-029 abort in LOAD SHALL return the FSM to IDLE on the next cycle.
REQ-030 An accept coinciding with abort SHALL still be written, but no further accepts SHALL occur and done SHALL NOT pulse.
REQ-031 start while the FSM is not in IDLE SHALL be ignored, with no error pulse.
REQ-032 cpu_hold SHALL equal busy OR write_to_imem.
REQ-033 busy SHALL be 1 in LOAD and DONE.
REQ-034 write_to_imem, addr_imem_host and imem_data SHALL all be registered outputs.

Reset
REQ-035 rst=1 SHALL force the FSM to IDLE and drive host_ready, write_to_imem, addr_imem_host, imem_data, cpu_hold, busy, done and error to 0 on the next edge.
REQ-036 rst during LOAD SHALL abandon the burst with no further writes and no done pulse.

Configuration
REQ-037 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL add port checksum  output  DATA_W  holding the sum modulo 2^32 of all accepted words.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined, checksum SHALL clear to 0 on reset and on an accepted start, and SHALL be final in the cycle done=1.
REQ-039 Without IMEM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 A bench SHALL check: start, base_addr=0x010, word_count=3, words 0xA0000001/0xA0000002/0xA0000003 back-to-back -> three write strobes at addresses 0x010/0x011/0x012, one done pulse, checksum=0xE0000006 when enabled.
REQ-041 A bench SHALL check: base_addr=0x1FF, word_count=2 -> writes at 0x1FF then 0x000.
REQ-042 A bench SHALL check: host_valid toggling 1,0,0,1 with word_count=2 -> exactly 2 writes, each 1 cycle after its accept, with cpu_hold held high throughout.
REQ-043 A bench SHALL check: start with word_count=0, and separately with 513 -> one error pulse each, busy stays 0, no writes.
REQ-044 A bench SHALL check: abort after 2 of 5 words -> 2 writes, no done, FSM in IDLE; a new start is then accepted.
REQ-045 A bench SHALL check: rst asserted mid-burst -> all outputs 0 on the next cycle and no subsequent write strobe.
